// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared types and AXI encodings for the icache/dcache AXI arbiter.
// Round-robin arbitration is enabled with YSYX_22050019_ARB_RR_EN.
package ysyx_22050019_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_D_AW = 2'd1,
        GNT_D_AR = 2'd2,
        GNT_I_AR = 2'd3
    } grant_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Cache rw_len is already beats-1, which is exactly AXI LEN.
    function automatic logic [7:0] axi_len(input logic rw_len);
        return {7'b0, rw_len};
    endfunction

endpackage

// File: rtl/ysyx_22050019_arb_pick.sv
// Combinational grant selection among dcache write, dcache read and icache read.
// With YSYX_22050019_ARB_RR_EN the icache/dcache choice alternates on conflict.
module ysyx_22050019_arb_pick
    import ysyx_22050019_axi_pkg::*;
(
    input  logic       d_aw_valid,
    input  logic       d_ar_valid,
    input  logic       i_ar_valid,
`ifdef YSYX_22050019_ARB_RR_EN
    input  logic       last_owner,
`endif
    output logic [1:0] grant
);

    logic d_req;
    logic d_first;

    assign d_req = d_aw_valid | d_ar_valid;

`ifdef YSYX_22050019_ARB_RR_EN
    // On a conflict the side that did not win last time goes first.
    assign d_first = (last_owner != OWN_D);
`else
    assign d_first = 1'b1;
`endif

    always_comb begin
        grant = GNT_NONE;
        if (d_req && (d_first || !i_ar_valid)) begin
            grant = d_aw_valid ? GNT_D_AW : GNT_D_AR;
        end else if (i_ar_valid) begin
            grant = GNT_I_AR;
        end
    end

endmodule

// File: rtl/ysyx_22050019_axi_arbiter.sv
// Shares one AXI4 master port between icache reads and dcache reads/writebacks.
// Define YSYX_22050019_ARB_RR_EN for round-robin icache/dcache arbitration.
module ysyx_22050019_axi_arbiter
    import ysyx_22050019_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      i_ar_valid_i,
    output logic                      i_ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]     i_ar_addr_i,
    input  logic                      i_rw_len_i,
    output logic                      i_r_valid_o,
    input  logic                      i_r_ready_i,
    output logic [DATA_WIDTH-1:0]     i_r_data_o,
    output logic [1:0]                i_r_resp_o,

    input  logic                      d_ar_valid_i,
    output logic                      d_ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]     d_ar_addr_i,
    input  logic                      d_rw_len_i,
    output logic                      d_r_valid_o,
    input  logic                      d_r_ready_i,
    output logic [DATA_WIDTH-1:0]     d_r_data_o,
    output logic [1:0]                d_r_resp_o,
    input  logic                      d_aw_valid_i,
    output logic                      d_aw_ready_o,
    input  logic [ADDR_WIDTH-1:0]     d_aw_addr_i,
    input  logic                      d_w_valid_i,
    output logic                      d_w_ready_o,
    input  logic [DATA_WIDTH-1:0]     d_w_data_i,
    input  logic [DATA_WIDTH/8-1:0]   d_w_strb_i,
    output logic                      d_b_valid_o,
    input  logic                      d_b_ready_i,
    output logic [1:0]                d_b_resp_o,

    output logic                      m_ar_valid_o,
    input  logic                      m_ar_ready_i,
    output logic [ADDR_WIDTH-1:0]     m_ar_addr_o,
    output logic [7:0]                m_ar_len_o,
    output logic [2:0]                m_ar_size_o,
    output logic [1:0]                m_ar_burst_o,
    input  logic                      m_r_valid_i,
    output logic                      m_r_ready_o,
    input  logic [DATA_WIDTH-1:0]     m_r_data_i,
    input  logic [1:0]                m_r_resp_i,
    input  logic                      m_r_last_i,
    output logic                      m_aw_valid_o,
    input  logic                      m_aw_ready_i,
    output logic [ADDR_WIDTH-1:0]     m_aw_addr_o,
    output logic [7:0]                m_aw_len_o,
    output logic [2:0]                m_aw_size_o,
    output logic [1:0]                m_aw_burst_o,
    output logic                      m_w_valid_o,
    input  logic                      m_w_ready_i,
    output logic [DATA_WIDTH-1:0]     m_w_data_o,
    output logic [DATA_WIDTH/8-1:0]   m_w_strb_o,
    output logic                      m_w_last_o,
    input  logic                      m_b_valid_i,
    output logic                      m_b_ready_o,
    input  logic [1:0]                m_b_resp_i
);

    state_t     state;
    owner_t     owner;
    logic       len;
    logic       cnt;
    logic [1:0] grant;
`ifdef YSYX_22050019_ARB_RR_EN
    owner_t     last_owner;
`endif

    ysyx_22050019_arb_pick u_pick (
        .d_aw_valid (d_aw_valid_i),
        .d_ar_valid (d_ar_valid_i),
        .i_ar_valid (i_ar_valid_i),
`ifdef YSYX_22050019_ARB_RR_EN
        .last_owner (last_owner),
`endif
        .grant      (grant)
    );

    // Every combinational path is qualified by rst so nothing leaks out while reset is held.
    logic idle;
    logic r_to_i;
    logic r_to_d;
    logic in_w;
    logic in_b;

    assign idle   = rst && (state == S_IDLE);
    assign r_to_i = rst && (state == S_R) && (owner == OWN_I);
    assign r_to_d = rst && (state == S_R) && (owner == OWN_D);
    assign in_w   = rst && (state == S_W);
    assign in_b   = rst && (state == S_B);

    assign d_aw_ready_o = idle && (grant == GNT_D_AW);
    assign d_ar_ready_o = idle && (grant == GNT_D_AR);
    assign i_ar_ready_o = idle && (grant == GNT_I_AR);

    assign i_r_valid_o = r_to_i && m_r_valid_i;
    assign i_r_data_o  = r_to_i ? m_r_data_i : '0;
    assign i_r_resp_o  = r_to_i ? m_r_resp_i : '0;
    assign d_r_valid_o = r_to_d && m_r_valid_i;
    assign d_r_data_o  = r_to_d ? m_r_data_i : '0;
    assign d_r_resp_o  = r_to_d ? m_r_resp_i : '0;
    assign m_r_ready_o = (r_to_i && i_r_ready_i) || (r_to_d && d_r_ready_i);

    assign m_w_valid_o = in_w && d_w_valid_i;
    assign d_w_ready_o = in_w && m_w_ready_i;
    assign m_w_data_o  = in_w ? d_w_data_i : '0;
    assign m_w_strb_o  = in_w ? d_w_strb_i : '0;
    assign m_w_last_o  = in_w && (cnt == len);

    assign d_b_valid_o = in_b && m_b_valid_i;
    assign d_b_resp_o  = in_b ? m_b_resp_i : '0;
    assign m_b_ready_o = in_b && d_b_ready_i;

    // Transaction FSM; the address-channel outputs are loaded at grant and held until accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            owner        <= OWN_I;
            len          <= 1'b0;
            cnt          <= 1'b0;
            m_ar_valid_o <= 1'b0;
            m_ar_addr_o  <= '0;
            m_ar_len_o   <= '0;
            m_ar_size_o  <= '0;
            m_ar_burst_o <= '0;
            m_aw_valid_o <= 1'b0;
            m_aw_addr_o  <= '0;
            m_aw_len_o   <= '0;
            m_aw_size_o  <= '0;
            m_aw_burst_o <= '0;
`ifdef YSYX_22050019_ARB_RR_EN
            last_owner   <= OWN_D;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= 1'b0;
`ifdef YSYX_22050019_ARB_RR_EN
                    if (grant != GNT_NONE) begin
                        last_owner <= (grant == GNT_I_AR) ? OWN_I : OWN_D;
                    end
`endif
                    case (grant)
                        GNT_D_AW: begin
                            owner        <= OWN_D;
                            len          <= d_rw_len_i;
                            m_aw_valid_o <= 1'b1;
                            m_aw_addr_o  <= d_aw_addr_i;
                            m_aw_len_o   <= axi_len(d_rw_len_i);
                            m_aw_size_o  <= AXI_SIZE_8B;
                            m_aw_burst_o <= AXI_BURST_INCR;
                            state        <= S_AW;
                        end
                        GNT_D_AR: begin
                            owner        <= OWN_D;
                            len          <= d_rw_len_i;
                            m_ar_valid_o <= 1'b1;
                            m_ar_addr_o  <= d_ar_addr_i;
                            m_ar_len_o   <= axi_len(d_rw_len_i);
                            m_ar_size_o  <= AXI_SIZE_8B;
                            m_ar_burst_o <= AXI_BURST_INCR;
                            state        <= S_AR;
                        end
                        GNT_I_AR: begin
                            owner        <= OWN_I;
                            len          <= i_rw_len_i;
                            m_ar_valid_o <= 1'b1;
                            m_ar_addr_o  <= i_ar_addr_i;
                            m_ar_len_o   <= axi_len(i_rw_len_i);
                            m_ar_size_o  <= AXI_SIZE_8B;
                            m_ar_burst_o <= AXI_BURST_INCR;
                            state        <= S_AR;
                        end
                        default: ;
                    endcase
                end
                S_AR: begin
                    if (m_ar_ready_i) begin
                        m_ar_valid_o <= 1'b0;
                        state        <= S_R;
                    end
                end
                S_R: begin
                    if (m_r_valid_i && m_r_ready_o && m_r_last_i) begin
                        state <= S_IDLE;
                    end
                end
                S_AW: begin
                    if (m_aw_ready_i) begin
                        m_aw_valid_o <= 1'b0;
                        state        <= S_W;
                    end
                end
                S_W: begin
                    if (m_w_valid_o && m_w_ready_i) begin
                        cnt <= cnt + 1'b1;
                        if (m_w_last_o) begin
                            state <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (m_b_valid_i && m_b_ready_o) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_22050019_axi_arbiter.md
# ysyx_22050019_axi_arbiter

- Shares one AXI4 master port between the instruction-cache and data-cache refill/writeback ports.
- Serializes one transaction at a time:
  - icache: read bursts only.
  - dcache: read bursts and dirty-line writeback bursts.
- Turns each cache's 1-bit `rw_len` (0 = 1 beat, 1 = 2 beats) into AXI INCR bursts.
- Sits between the two caches and the SoC crossbar/memory bus.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 64, beat width; strobe is `DATA_WIDTH/8`.

Ports (pairs listed as valid/ready):
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `i_ar_valid_i` / `i_ar_ready_o`  in/out  1  icache read-address handshake.
- `i_ar_addr_i`, `i_rw_len_i`  in  `ADDR_WIDTH`, 1  icache burst address, beats−1.
- `i_r_valid_o` / `i_r_ready_i`  out/in  1  icache read-data handshake.
- `i_r_data_o`, `i_r_resp_o`  out  `DATA_WIDTH`, 2  icache read beat, response.
- `d_ar_*`, `d_r_*`  same shapes as the icache ports  dcache read channel.
- `d_aw_valid_i` / `d_aw_ready_o`, `d_aw_addr_i`, `d_rw_len_i`  dcache write address.
- `d_w_valid_i` / `d_w_ready_o`, `d_w_data_i`, `d_w_strb_i`  dcache write data.
- `d_b_valid_o` / `d_b_ready_i`, `d_b_resp_o`  dcache write response.
- `m_ar_valid_o` / `m_ar_ready_i`, `m_ar_addr_o`, `m_ar_len_o[7:0]`, `m_ar_size_o[2:0]`, `m_ar_burst_o[1:0]`  master AR.
- `m_r_valid_i` / `m_r_ready_o`, `m_r_data_i`, `m_r_resp_i[1:0]`, `m_r_last_i`  master R.
- `m_aw_valid_o` / `m_aw_ready_i`, `m_aw_addr_o`, `m_aw_len_o`, `m_aw_size_o`, `m_aw_burst_o`  master AW.
- `m_w_valid_o` / `m_w_ready_i`, `m_w_data_o`, `m_w_strb_o`, `m_w_last_o`  master W.
- `m_b_valid_i` / `m_b_ready_o`, `m_b_resp_i[1:0]`  master B.

## Operation
- States: `S_IDLE`, `S_AR`, `S_R`, `S_AW`, `S_W`, `S_B`.
- Registers: `owner` (I/D), latched `addr`, latched `len`, beat counter `cnt` (1 bit).
- `S_IDLE` grant, fixed priority: `d_aw` > `d_ar` > `i_ar`.
  - The winner's `*_ready_o` is driven combinationally high in that cycle.
  - Address and len are latched; `cnt` is cleared.
  - Next state: `S_AW` for a write, `S_AR` for a read.
- `S_AR`:
  - Registered `m_ar_valid_o` = 1; `m_ar_len_o` = `{7'b0, len}`; `m_ar_size_o` = 3'b011; `m_ar_burst_o` = 2'b01.
  - Go to `S_R` on `m_ar` handshake.
- `S_R`, combinational forward to the owner:
  - `owner_r_valid` = `m_r_valid_i`; `m_r_ready_o` = `owner_r_ready`; data/resp pass through.
  - Handshake with `m_r_last_i` → `S_IDLE`.
  - The non-owner's `r_valid` is 0.
- `S_AW`: registered `m_aw_valid_o`, same len/size/burst encoding; handshake → `S_W`.
- `S_W`:
  - Forward `d_w` ↔ `m_w`.
  - `m_w_last_o` = (`cnt` == `len`); `cnt` increments per handshake.
  - Handshake on the last beat → `S_B`.
- `S_B`: forward `m_b` ↔ `d_b`; handshake → `S_IDLE`.
- Responses are forwarded unmodified. A nonzero RRESP/BRESP does not abort or shorten a burst.
- Reset values, all outputs: valid/ready 0; addr, data, len, size, burst, strb, resp 0; `m_w_last_o` 0.
- Reset mid-burst: return to `S_IDLE` immediately and drop the transaction. The bus slave is reset by the same reset.

## Timing
- Request to `m_*_valid`: 1 cycle (grant cycle, then `S_AR`/`S_AW`).
- Data beats add 0 cycles; R/W/B are combinational pass-through.
- `S_R`/`S_B` → `S_IDLE` takes 1 cycle. Back-to-back transactions: 1 idle cycle minimum between the last R/B handshake and the next grant.
- `m_ar_valid_o`/`m_aw_valid_o` stay high until `ready`; address is stable while valid.
- Simultaneous `i_ar` and `d_ar`: only one ready is raised. The loser's valid must remain held; the loser is granted in the next `S_IDLE`.
- All `*_ready_o` toward the caches are 0 outside `S_IDLE` (address channels) or outside the owning data state.

## Configuration
- `YSYX_22050019_ARB_RR_EN` defined: icache vs dcache is round-robin.
  - `last_owner` is updated at each grant; on conflict, the side not granted last wins.
  - Within dcache, `aw` still precedes `ar`.
- Undefined: fixed priority `d_aw` > `d_ar` > `i_ar`; the icache can starve while the dcache requests continuously.

## Structure
- Package `ysyx_22050019_axi_pkg`:
  - state encoding;
  - `AXI_BURST_INCR` = 2'b01, `AXI_SIZE_8B` = 3'b011;
  - `AXI_RESP_OKAY`/`SLVERR`;
  - owner encoding `OWN_I` / `OWN_D`.
- Sub-module `ysyx_22050019_arb_pick`: combinational grant from `{d_aw, d_ar, i_ar}` valids plus the RR pointer (RR pointer present only under the macro).
- Top holds the FSM and the channel muxes.

## Test plan
- icache read `0x8000_0010`, len 1; slave returns `0x11`, `0x22` (last).
  - `m_ar_len_o` = 1, size 3, burst 1.
  - `i_r_data_o` shows `0x11` then `0x22`; state back to `S_IDLE`.
- dcache writeback `0x8000_0100`, len 1, data `0xAA`/`0xBB`, strb `0xFF`.
  - `m_w_last_o` = 0 then 1; `d_b_valid_o` is seen with resp 0.
- `i_ar` and `d_ar` asserted in the same cycle.
  - Fixed build: dcache first, icache second.
  - RR build with `last_owner` = D: icache first.
- `m_ar_ready_i` held low 5 cycles: `m_ar_valid_o` and `m_ar_addr_o` stay stable; no cache ready is raised.
- `m_r_valid_i` gaps (valid 0 for 3 cycles between beats) and `i_r_ready_i` low for 2 cycles: no beat lost or duplicated.
- `rst` driven 0 during `S_W` beat 0: next cycle all valids are 0 and state is `S_IDLE`; a new `i_ar` after release is granted normally.
